i2s_audio_receiver: RTL and testbench

Deserialises a standard I2S stereo stream into parallel 16-bit left/right samples. It produces the single-cycle `audio_enable` strobe and the `l_audio_signal`/`r_audio_signal` sample bus consumed by the VU meter driver and the other audio-path blocks. All I2S pins are asynchronous to `clk` and are synchronised internally. Nominal operation is `clk` = 49.152 MHz, fs = 96 kHz and BCLK = 64·fs = 6.144 MHz (8 `clk` per BCLK).

---
 rtl/i2s_audio_receiver.sv | 139 +++++++++++++
 tb/tb_i2s_audio_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_receiver.sv
// I2S stereo receiver: synchronises BCLK/LRCLK/DATA into clk, deserialises
// MSB-first samples and presents registered L/R pairs with a one-cycle strobe.
module i2s_audio_receiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lrclk,
    input  logic                   i2s_data,
    output logic [SAMPLE_BITS-1:0] l_audio_signal,
    output logic [SAMPLE_BITS-1:0] r_audio_signal,
    output logic                   audio_enable,
    output logic                   frame_error,
    output logic                   locked
);
    localparam int CW = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(SAMPLE_BITS - 1);
    localparam logic [CW-1:0] CNT_SAMPLE   = CW'(SAMPLE_BITS);
    localparam logic [CW-1:0] CNT_SLOT_END = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] CNT_SAT      = CW'(SLOT_BITS);

    typedef enum logic [1:0] {HUNT = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, data_sync;
    logic                   bclk_d, lr_prev, l_valid, commit;
    logic [CW-1:0]          slot_cnt;
    logic [SAMPLE_BITS-2:0] shreg;
    logic [SAMPLE_BITS-1:0] l_hold, r_hold, word;

    logic sync_bclk, sync_lr, sync_data;
    logic rise, change, data_rise, last_bit, slot_ok;
    logic store_left, commit_nxt, frame_err_nxt;

    assign sync_bclk = bclk_sync[SYNC_STAGES-1];
    assign sync_lr   = lr_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    assign rise      = sync_bclk & ~bclk_d;
    assign change    = rise & (sync_lr ^ lr_prev);
    assign data_rise = rise & ~change;
    assign last_bit  = data_rise & (slot_cnt == CNT_LAST);
    // Slot of SLOT_BITS BCLKs = one change rise plus SLOT_BITS-1 counted rises.
    assign slot_ok   = (slot_cnt == CNT_SLOT_END);
    assign word      = {shreg, sync_data};
    assign locked    = (state != HUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        store_left    = 1'b0;
        commit_nxt    = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            HUNT: begin
                if (change && !sync_lr) state_nxt = LEFT;
            end
            LEFT: begin
                store_left = last_bit;
                if (change) begin
                    if (slot_ok) begin
                        state_nxt = RIGHT;
                    end else begin
                        state_nxt     = HUNT;
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            RIGHT: begin
                commit_nxt = last_bit & l_valid;
                if (change) begin
                    if (slot_ok) begin
                        state_nxt = LEFT;
                    end else begin
                        state_nxt     = HUNT;
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync      <= '0;
            lr_sync        <= '0;
            data_sync      <= '0;
            bclk_d         <= 1'b0;
            lr_prev        <= 1'b0;
            slot_cnt       <= '0;
            shreg          <= '0;
            l_hold         <= '0;
            r_hold         <= '0;
            l_valid        <= 1'b0;
            commit         <= 1'b0;
            audio_enable   <= 1'b0;
            frame_error    <= 1'b0;
            l_audio_signal <= '0;
            r_audio_signal <= '0;
        end else begin
            bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync      <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            data_sync    <= {data_sync[SYNC_STAGES-2:0], i2s_data};
            bclk_d       <= sync_bclk;
            frame_error  <= frame_err_nxt;
            commit       <= commit_nxt;
            audio_enable <= commit;
            if (commit) begin
                l_audio_signal <= l_hold;
                r_audio_signal <= r_hold;
            end
            if (rise) lr_prev <= sync_lr;
            if (change) begin
                slot_cnt <= '0;
            end else if (data_rise) begin
                if (slot_cnt < CNT_SAMPLE) shreg <= word[SAMPLE_BITS-2:0];
                if (slot_cnt != CNT_SAT)   slot_cnt <= slot_cnt + CW'(1);
            end
            // A left word only pairs with the right slot that directly follows it.
            if (state_nxt == HUNT || (change && state == RIGHT)) l_valid <= 1'b0;
            if (store_left) begin
                l_hold  <= word;
                l_valid <= 1'b1;
            end
            if (commit_nxt) begin
                r_hold  <= word;
                l_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Randomised bench for i2s_audio_receiver: slot-level reference model feeds a
// scoreboard of expected sample pairs / frame errors with their arrival cycle.
module tb_i2s_audio_receiver;
    localparam int SB   = 16;
    localparam int SLOT = 32;
    localparam int SS   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_data = 1'b0;
    logic [SB-1:0] l_audio_signal, r_audio_signal;
    logic          audio_enable, frame_error, locked;

    i2s_audio_receiver #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_data(i2s_data), .l_audio_signal(l_audio_signal),
        .r_audio_signal(r_audio_signal), .audio_enable(audio_enable),
        .frame_error(frame_error), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    typedef struct {logic [SB-1:0] l; logic [SB-1:0] r; int cyc;} exp_t;
    exp_t          exp_q[$];
    int            err_q[$];
    exp_t          e;
    logic [SB-1:0] last_l = '0, last_r = '0;

    // Reference model, evaluated once per slot at its LRCLK change.
    bit            rst_held = 1'b1, locked_m = 1'b0, have_left = 1'b0;
    int            prev_len = SLOT;
    logic [SB-1:0] l_m;

    task automatic model_slot(input logic lr, input logic [SB-1:0] s, input int len);
        if (rst_held) begin
            locked_m  = 1'b0;
            have_left = 1'b0;
        end else begin
            if (locked_m && prev_len != SLOT) begin
                // BCLK rise of slot bit 0 is first sampled 5 cycles in; error is registered.
                err_q.push_back(cyc + 5 + SS);
                locked_m  = 1'b0;
                have_left = 1'b0;
            end else if (!locked_m && lr == 1'b0) begin
                locked_m = 1'b1;
            end
            if (locked_m && lr == 1'b0) have_left = 1'b0;
            if (locked_m && len > SB) begin
                if (lr == 1'b0) begin
                    l_m       = s;
                    have_left = 1'b1;
                end else if (have_left) begin
                    // Sampling edge of bit SB counts as the first of SS+2 edges.
                    exp_q.push_back('{l_m, s, cyc + 8 * SB + 5 + SS + 1});
                    have_left = 1'b0;
                end
            end
        end
        prev_len = len;
    endtask

    // One BCLK period: fall (lr/data change), 4 clk low, rise, 4 clk high.
    task automatic bclk_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = d;
        repeat (4) @(posedge clk);
        #3 i2s_bclk = 1'b1;
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic send_slot(input logic lr, input logic [SB-1:0] s, input int len,
                             input int from, input int upto);
        logic b;
        if (from == 0) model_slot(lr, s, len);
        for (int i = from; i < upto; i++) begin
            if (i >= 1 && i <= SB) b = s[SB - i];
            else                   b = 1'($urandom_range(0, 1));
            bclk_bit(lr, b);
        end
    endtask

    task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
        send_slot(1'b0, l, SLOT, 0, SLOT);
        send_slot(1'b1, r, SLOT, 0, SLOT);
    endtask

    task automatic assert_reset();
        reset     = 1'b0;
        rst_held  = 1'b1;
        locked_m  = 1'b0;
        have_left = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        while (err_q.size() > 0 && err_q[$] > cyc) void'(err_q.pop_back());
        last_l = '0;
        last_r = '0;
        #1;
        check("rst_l", 32'(l_audio_signal), 32'h0);
        check("rst_r", 32'(r_audio_signal), 32'h0);
        check("rst_enable", 32'(audio_enable), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        rst_held = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (audio_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_enable", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("l_sample", 32'(l_audio_signal), 32'(e.l));
                    check("r_sample", 32'(r_audio_signal), 32'(e.r));
                    check("enable_cycle", 32'(cyc), 32'(e.cyc));
                end
                last_l = l_audio_signal;
                last_r = r_audio_signal;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missing_enable", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (frame_error) begin
                if (err_q.size() == 0) check("unexpected_frame_error", 32'h1, 32'h0);
                else                   check("frame_error_cycle", 32'(cyc), 32'(err_q.pop_front()));
                check("locked_on_error", 32'(locked), 32'h0);
                check("l_hold_on_error", 32'(l_audio_signal), 32'(last_l));
                check("r_hold_on_error", 32'(r_audio_signal), 32'(last_r));
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                check("missing_frame_error", 32'(cyc), 32'(err_q[0]));
                void'(err_q.pop_front());
            end
        end
    end

    logic [SB-1:0] pats [10];
    logic [SB-1:0] a, b;

    initial begin
        pats = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8000, 16'h7FFF,
                 16'h0001, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 7; i < 10; i++) pats[i] = 16'($urandom);

        @(posedge clk);
        #3;
        // Reset held while BCLK toggles
        assert_reset();
        send_frame(16'($urandom), 16'($urandom));
        check("held_l", 32'(l_audio_signal), 32'h0);
        check("held_enable", 32'(audio_enable), 32'h0);
        check("held_locked", 32'(locked), 32'h0);
        release_reset();
        send_slot(1'b1, 16'($urandom), SLOT, 0, SLOT);
        check("locked_before_left", 32'(locked), 32'h0);

        // Nominal frame, then ten-frame stream
        send_frame(16'h8001, 16'h7FFE);
        for (int k = 0; k < 10; k++) send_frame(pats[k], ~pats[k]);
        check("locked_stream", 32'(locked), 32'h1);

        // Short left slot (20 BCLKs)
        send_slot(1'b0, 16'($urandom), 20, 0, 20);
        send_slot(1'b1, 16'($urandom), SLOT, 0, SLOT);
        check("locked_after_short", 32'(locked), 32'h0);
        for (int k = 0; k < 2; k++) send_frame(16'($urandom), 16'($urandom));

        // Over-long right slot: pair commits, then the slot-length error
        send_slot(1'b0, 16'($urandom), SLOT, 0, SLOT);
        send_slot(1'b1, 16'($urandom), 40, 0, 40);
        for (int k = 0; k < 2; k++) send_frame(16'($urandom), 16'($urandom));

        // Reset asserted and released inside a right slot
        a = 16'($urandom);
        b = 16'($urandom);
        send_slot(1'b0, a, SLOT, 0, SLOT);
        send_slot(1'b1, b, SLOT, 0, 10);
        assert_reset();
        send_slot(1'b1, b, SLOT, 10, 20);
        release_reset();
        send_slot(1'b1, b, SLOT, 20, SLOT);
        for (int k = 0; k < 2; k++) send_frame(16'($urandom), 16'($urandom));

        // Reset during a left slot
        a = 16'($urandom);
        send_slot(1'b0, a, SLOT, 0, 12);
        assert_reset();
        send_slot(1'b0, a, SLOT, 12, 20);
        release_reset();
        send_slot(1'b0, a, SLOT, 20, SLOT);
        send_slot(1'b1, 16'($urandom), SLOT, 0, SLOT);
        for (int k = 0; k < 3; k++) send_frame(16'($urandom), 16'($urandom));
        send_slot(1'b0, 16'($urandom), SLOT, 0, SLOT);

        check("pending_enables", 32'(exp_q.size()), 32'h0);
        check("pending_errors", 32'(err_q.size()), 32'h0);
        check("l_hold_end", 32'(l_audio_signal), 32'(last_l));
        check("r_hold_end", 32'(r_audio_signal), 32'(last_r));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
